// File: rtl/text_char_buffer_pkg.sv
// vga_text_pkg: text-mode geometry, control codes and write-FSM states shared by the char buffer.
package vga_text_pkg;
   localparam int COLS   = 80;
   localparam int ROWS   = 30;
   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = $clog2(CELLS);
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_SPACE = 8'h20;
   typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction
endpackage

// File: rtl/text_char_buffer_ram.sv
// text_ram: simple dual-port character RAM, one write port and one registered read-before-write read port.
module text_ram #(
   parameter int DEPTH = 2400,
   parameter int AW    = 12,
   parameter int W     = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  q
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
   end
endmodule

// File: rtl/text_char_buffer.sv
// text_char_buffer: text-mode character store fed by the calculator byte stream and scanned by VGA.
module text_char_buffer
   import vga_text_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       in_display_area,
   output logic [7:0] glyph_char,
   output logic [3:0] glyph_row,
   output logic [2:0] glyph_col,
   output logic       glyph_active,
   output logic       glyph_cursor,
   output logic [6:0] cursor_col,
   output logic [4:0] cursor_row
);
   localparam int CW_B = $clog2(CHAR_W);
   localparam int CH_B = $clog2(CHAR_H);
   state_t state;
   logic [ADDR_W-1:0] cnt, waddr, raddr;
   logic [7:0] wdata, q;
   logic we, take, printable, newline;
   logic [4:0] next_row;
   logic [6:0] col0;
   logic [4:0] row0;
   logic [CW_B-1:0] gc0;
   logic [CH_B-1:0] gr0;
   logic act0;
   assign take = state == IDLE && char_valid && char_ready;
   assign printable = char_in >= 8'h20 && char_in <= 8'h7E;
   assign newline = char_in == CH_LF || char_in == CH_CR;
   assign next_row = cursor_row == 5'(ROWS - 1) ? 5'd0 : cursor_row + 5'd1;
   // Clears reuse cnt as the address; in CLEAR_ROW cursor_row already points at the entered row.
   always_comb begin
      we = !reset && (state == CLEAR_ALL || state == CLEAR_ROW ||
           (take && (printable || (char_in == CH_BS && cursor_col != 7'd0))));
      waddr = state == CLEAR_ALL ? cnt :
              state == CLEAR_ROW ? cell_addr(cursor_row, cnt[6:0]) :
              cell_addr(cursor_row, char_in == CH_BS ? cursor_col - 7'd1 : cursor_col);
      wdata = state == IDLE && printable ? char_in : CH_SPACE;
      raddr = cell_addr(row0, col0);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR_ALL;
         cnt <= '0;
         char_ready <= 1'b0;
         cursor_col <= '0;
         cursor_row <= '0;
      end else begin
         case (state)
            CLEAR_ALL, CLEAR_ROW: begin
               if (cnt == (state == CLEAR_ALL ? ADDR_W'(CELLS - 1) : ADDR_W'(COLS - 1))) begin
                  state <= IDLE;
                  char_ready <= 1'b1;
                  cnt <= '0;
               end else cnt <= cnt + 1'b1;
            end
            IDLE: if (take) begin
               if (char_in == CH_FF) begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  state <= CLEAR_ALL;
                  char_ready <= 1'b0;
               end else if (newline || (printable && cursor_col == 7'(COLS - 1))) begin
                  cursor_col <= '0;
                  cursor_row <= next_row;
                  state <= CLEAR_ROW;
                  char_ready <= 1'b0;
               end else if (printable) cursor_col <= cursor_col + 7'd1;
               else if (char_in == CH_BS && cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
            end
            default: begin
               state <= IDLE;
               char_ready <= 1'b1;
            end
         endcase
      end
   end
   // Stage 0 splits the pixel into cell and glyph offsets; stage 1 aligns them with the RAM read.
   always_ff @(posedge clk) begin
      if (reset) begin
         col0 <= '0;
         row0 <= '0;
         gc0 <= '0;
         gr0 <= '0;
         act0 <= 1'b0;
         glyph_row <= '0;
         glyph_col <= '0;
         glyph_active <= 1'b0;
         glyph_cursor <= 1'b0;
      end else begin
         col0 <= 7'(x >> CW_B);
         row0 <= 5'(y >> CH_B);
         gc0 <= x[CW_B-1:0];
         gr0 <= y[CH_B-1:0];
         act0 <= in_display_area && x < 10'(COLS * CHAR_W) && y < 10'(ROWS * CHAR_H);
         glyph_row <= gr0;
         glyph_col <= gc0;
         glyph_active <= act0;
         glyph_cursor <= act0 && col0 == cursor_col && row0 == cursor_row;
      end
   end
   assign glyph_char = glyph_active ? q : CH_SPACE;
   text_ram #(.DEPTH(CELLS), .AW(ADDR_W), .W(8)) ram (
      .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .q(q)
   );
endmodule

// File: tb/tb_text_char_buffer.sv
// tb_text_char_buffer: randomized scoreboard bench against a cell-array model of the text buffer.
module tb_text_char_buffer;
   logic clk = 1'b0, reset = 1'b0, char_valid = 1'b0, in_display_area = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic [9:0] x = '0, y = '0;
   logic char_ready, glyph_active, glyph_cursor;
   logic [7:0] glyph_char;
   logic [3:0] glyph_row;
   logic [2:0] glyph_col;
   logic [6:0] cursor_col;
   logic [4:0] cursor_row;
   text_char_buffer dut (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
      .x(x), .y(y), .in_display_area(in_display_area), .glyph_char(glyph_char), .glyph_row(glyph_row),
      .glyph_col(glyph_col), .glyph_active(glyph_active), .glyph_cursor(glyph_cursor),
      .cursor_col(cursor_col), .cursor_row(cursor_row)
   );
   always #5 clk = ~clk;
   typedef struct {
      int         due;
      logic [7:0] ch;
      logic [3:0] row;
      logic [2:0] col;
      logic       act;
      logic       cur;
   } exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0, cyc = 0;
   logic [7:0] mem [30][80];
   int ccol = 0, crow = 0, busy = 0, pend = -1;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", n, cyc, act, exp);
      end
   endtask
   function automatic void advance();
      ccol = 0;
      crow = (crow + 1) % 30;
      busy = 80;
      pend = crow;
   endfunction
   function automatic void consume(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         mem[crow][ccol] = b;
         if (ccol == 79) advance();
         else ccol++;
      end else if (b == 8'h0A || b == 8'h0D) advance();
      else if (b == 8'h08) begin
         if (ccol > 0) begin
            ccol--;
            mem[crow][ccol] = 8'h20;
         end
      end else if (b == 8'h0C) begin
         ccol = 0;
         crow = 0;
         busy = 2400;
         pend = -1;
      end
   endfunction
   function automatic void finish_clear();
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            if (pend < 0 || pend == r) mem[r][c] = 8'h20;
   endfunction
   task automatic step(input logic v, input logic [7:0] b, input int px, input int py, input logic pd,
                       input logic r = 1'b0);
      logic idle_now;
      int cx, cy;
      exp_t e;
      idle_now = busy == 0 && !r;
      reset = r;
      char_valid = v && idle_now;
      char_in = b;
      x = r ? 10'd0 : 10'(px);
      y = r ? 10'd0 : 10'(py);
      in_display_area = pd && idle_now;
      @(posedge clk);
      cyc++;
      #1;
      if (r) begin
         busy = 2400;
         pend = -1;
         ccol = 0;
         crow = 0;
         sb.delete();
         sb.push_back('{cyc, 8'h20, 4'd0, 3'd0, 1'b0, 1'b0});
      end else if (busy > 0) begin
         busy--;
         if (busy == 0) finish_clear();
      end else if (char_valid) consume(char_in);
      chk("char_ready", 32'(char_ready), 32'(busy == 0));
      chk("cursor_col", 32'(cursor_col), 32'(ccol));
      chk("cursor_row", 32'(cursor_row), 32'(crow));
      cx = int'(x) / 8;
      cy = int'(y) / 16;
      e.due = cyc + 1;
      e.act = in_display_area && x < 10'd640 && y < 10'd480;
      e.ch = e.act ? mem[cy][cx] : 8'h20;
      e.row = 4'(int'(y) % 16);
      e.col = 3'(int'(x) % 8);
      e.cur = e.act && cx == ccol && cy == crow;
      sb.push_back(e);
      reset = 1'b0;
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("glyph_char", 32'(glyph_char), 32'(e.ch));
         chk("glyph_row", 32'(glyph_row), 32'(e.row));
         chk("glyph_col", 32'(glyph_col), 32'(e.col));
         chk("glyph_active", 32'(glyph_active), 32'(e.act));
         chk("glyph_cursor", 32'(glyph_cursor), 32'(e.cur));
      end
   end
   task automatic rnd_read(input logic v, input logic [7:0] b);
      step(v, b, $urandom_range(0, 719), $urandom_range(0, 519), $urandom_range(0, 9) != 0);
   endtask
   task automatic wait_idle();
      while (busy > 0) rnd_read(1'b0, 8'h00);
   endtask
   task automatic send(input logic [7:0] b);
      wait_idle();
      rnd_read(1'b1, b);
   endtask
   function automatic logic [7:0] rnd_byte();
      int r;
      logic [7:0] v;
      r = $urandom_range(0, 99);
      v = 8'($urandom_range(0, 255));
      if (v == 8'h0C) v = 8'h7F;
      return r < 70 ? 8'($urandom_range(32, 126)) : r < 76 ? 8'h0A : r < 80 ? 8'h0D :
             r < 90 ? 8'h08 : v;
   endfunction
   initial begin
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++) mem[r][c] = 8'h20;
      step(1'b0, 8'h00, 0, 0, 1'b0, 1'b1);
      wait_idle();
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            step(1'b0, 8'h00, c * 8 + $urandom_range(0, 7), r * 16 + $urandom_range(0, 15), 1'b1);
      step(1'b1, 8'h41, 3, 5, 1'b1);
      step(1'b0, 8'h00, 3, 5, 1'b1);
      step(1'b0, 8'h00, 8, 0, 1'b1);
      send(8'h0C);
      wait_idle();
      for (int i = 0; i < 80; i++) step(1'b1, 8'h31, 632 + $urandom_range(0, 7), $urandom_range(0, 15), 1'b1);
      wait_idle();
      step(1'b0, 8'h00, 632, 0, 1'b1);
      for (int i = 0; i < 28; i++) send(8'h0A);
      for (int i = 0; i < 7; i++) send(8'h37);
      send(8'h0A);
      wait_idle();
      for (int c = 0; c < 80; c++) step(1'b0, 8'h00, c * 8, $urandom_range(0, 31), 1'b1);
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
      send(8'h08);
      for (int c = 0; c < 6; c++) step(1'b0, 8'h00, c * 8, 32, 1'b1);
      for (int i = 0; i < 5; i++) send(8'h08);
      step(1'b0, 8'h00, 0, 32, 1'b1);
      for (int i = 0; i < 3000; i++) rnd_read($urandom_range(0, 9) < 7, rnd_byte());
      wait_idle();
      send(8'h0C);
      repeat (1000) rnd_read(1'b0, 8'h00);
      step(1'b0, 8'h00, 0, 0, 1'b0, 1'b1);
      wait_idle();
      step(1'b0, 8'h00, 700, 100, 1'b1);
      step(1'b0, 8'h00, 100, 100, 1'b0);
      step(1'b0, 8'h00, 100, 479, 1'b1);
      step(1'b0, 8'h00, 639, 480, 1'b1);
      repeat (3) step(1'b0, 8'h00, 0, 0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
